tdc_sequencer: RTL and testbench

//  Measurement sequencer for the fine delay-chain capture block. Drives the Start/Stop column

---
 rtl/tdc_sequencer_pkg.sv | 15 +
 rtl/tdc_sequencer_coarse_counter.sv | 27 ++
 rtl/tdc_sequencer.sv | 137 +++++++++++++
 tb/tb_tdc_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/tdc_sequencer_pkg.sv
// Shared types and defaults for the TDC measurement sequencer.
package tdc_sequencer_pkg;

   localparam int unsigned DEFAULT_CW = 16;

   // Sequencer state encoding (3-bit, fixed values seen by debug readout)
   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_CLEAR      = 3'd1,
      S_WAIT_START = 3'd2,
      S_WAIT_STOP  = 3'd3,
      S_DONE       = 3'd4
   } seqState_t;

endpackage

// File: rtl/tdc_sequencer_coarse_counter.sv
// Saturating coarse cycle counter with synchronous clear and count enable.
module tdc_coarse_counter
   import tdc_sequencer_pkg::*;
#(
   parameter int unsigned CW = DEFAULT_CW
) (
   input  logic          clk,
   input  logic          iRst,
   input  logic          iClear,
   input  logic          iEnable,
   output logic [CW-1:0] oCount
);

   localparam logic [CW-1:0] COUNT_MAX = '1;

   // Count up while enabled, hold at all-ones instead of wrapping
   always_ff @(posedge clk or posedge iRst) begin
      if (iRst) begin
         oCount <= '0;
      end else if (iClear) begin
         oCount <= '0;
      end else if (iEnable && (oCount != COUNT_MAX)) begin
         oCount <= oCount + CW'(1);
      end
   end

endmodule

// File: rtl/tdc_sequencer.sv
// Measurement sequencer for the fine delay-chain capture block.
// Optional feature macro: TDC_SEQ_TIMEOUT_EN (abort a pending stop at TIMEOUT).
module tdc_sequencer
   import tdc_sequencer_pkg::*;
#(
   parameter int unsigned CW         = DEFAULT_CW,
   parameter int unsigned CLR_CYCLES = 2,
   parameter int unsigned GUARD      = 1,
   parameter int unsigned TIMEOUT    = 1000
) (
   input  logic          clk,
   input  logic          iRst,
   input  logic          iArm,
   input  logic          iAbort,
   input  logic          iArbStart,
   input  logic          iArbStop,
   output logic          oFineRst,
   output logic          oStartEnable,
   output logic          oStopEnable,
   output logic [CW-1:0] oCoarse,
   output logic          oTimeout,
   output logic          oValid,
   input  logic          iReady,
   output logic          oBusy
);

`ifdef TDC_SEQ_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   localparam int unsigned CLRW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

   seqState_t       state;
   seqState_t       stateNext;
   logic [CW-1:0]   count;
   logic            cntClear;
   logic            cntEnable;
   logic [CLRW-1:0] clrCnt;
   logic            clrDone;
   logic            stopQual;
   logic            timeoutHit;

   tdc_coarse_counter #(
      .CW      (CW)
   ) uCounter (
      .clk     (clk),
      .iRst    (iRst),
      .iClear  (cntClear),
      .iEnable (cntEnable),
      .oCount  (count)
   );

   assign clrDone    = (clrCnt == CLRW'(CLR_CYCLES - 1));
   assign stopQual   = (state == S_WAIT_STOP) && iArbStop && (count >= CW'(GUARD));
   assign timeoutHit = TIMEOUT_EN && (state == S_WAIT_STOP) && (count == CW'(TIMEOUT));

   // State register
   always_ff @(posedge clk or posedge iRst) begin
      if (iRst) begin
         state <= S_IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state logic; abort overrides everything outside IDLE
   always_comb begin
      stateNext = state;
      if ((state != S_IDLE) && iAbort) begin
         stateNext = S_IDLE;
      end else begin
         case (state)
            S_IDLE:       if (iArm && !iAbort)         stateNext = S_CLEAR;
            S_CLEAR:      if (clrDone)                 stateNext = S_WAIT_START;
            S_WAIT_START: if (iArbStart)               stateNext = S_WAIT_STOP;
            S_WAIT_STOP:  if (stopQual || timeoutHit)  stateNext = S_DONE;
            S_DONE:       if (iReady)                  stateNext = S_IDLE;
            default:                                   stateNext = S_IDLE;
         endcase
      end
   end

   // Column enables freeze in the same cycle their tap fires; counter runs only in WAIT_STOP
   always_comb begin
      oStartEnable = 1'b0;
      oStopEnable  = 1'b0;
      cntClear     = 1'b1;
      cntEnable    = 1'b0;
      case (state)
         S_WAIT_START: oStartEnable = !iArbStart;
         S_WAIT_STOP: begin
            oStopEnable = !stopQual;
            cntClear    = 1'b0;
            cntEnable   = 1'b1;
         end
         default: ;
      endcase
   end

   // CLEAR dwell counter
   always_ff @(posedge clk or posedge iRst) begin
      if (iRst) begin
         clrCnt <= '0;
      end else if (state == S_CLEAR) begin
         clrCnt <= clrCnt + CLRW'(1);
      end else begin
         clrCnt <= '0;
      end
   end

   // Registered status outputs and result capture (stop beats a same-cycle timeout)
   always_ff @(posedge clk or posedge iRst) begin
      if (iRst) begin
         oFineRst <= 1'b1;
         oBusy    <= 1'b0;
         oValid   <= 1'b0;
         oCoarse  <= '0;
         oTimeout <= 1'b0;
      end else begin
         oFineRst <= (stateNext == S_CLEAR);
         oBusy    <= (stateNext != S_IDLE);
         oValid   <= (stateNext == S_DONE);
         if (!iAbort) begin
            if (stopQual) begin
               oCoarse  <= count;
               oTimeout <= 1'b0;
            end else if (timeoutHit) begin
               oCoarse  <= CW'(TIMEOUT);
               oTimeout <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_tdc_sequencer.sv
// Self-checking bench for tdc_sequencer; honours TDC_SEQ_TIMEOUT_EN when defined.
module tb_tdc_sequencer;

`ifdef TDC_SEQ_TIMEOUT_EN
   localparam int unsigned CW    = 8;
   localparam bit          TO_EN = 1'b1;
   localparam int unsigned TMO   = 20;
`else
   localparam int unsigned CW    = 4;
   localparam bit          TO_EN = 1'b0;
   localparam int unsigned TMO   = 10;
`endif
   localparam int unsigned CLR   = 2;
   localparam int unsigned GUARD = 1;
   localparam int          MAXC  = (1 << CW) - 1;

   logic clk = 1'b0;
   logic iRst, iArm, iAbort, iArbStart, iArbStop, iReady;
   logic oFineRst, oStartEnable, oStopEnable, oTimeout, oValid, oBusy;
   logic [CW-1:0] oCoarse;

   int passCnt = 0;
   int failCnt = 0;
   int totalCnt = 0;
   int lastCoarse = 0;

   always #5 clk = ~clk;

   tdc_sequencer #(
      .CW           (CW),
      .CLR_CYCLES   (CLR),
      .GUARD        (GUARD),
      .TIMEOUT      (TMO)
   ) dut (
      .clk          (clk),
      .iRst         (iRst),
      .iArm         (iArm),
      .iAbort       (iAbort),
      .iArbStart    (iArbStart),
      .iArbStop     (iArbStop),
      .oFineRst     (oFineRst),
      .oStartEnable (oStartEnable),
      .oStopEnable  (oStopEnable),
      .oCoarse      (oCoarse),
      .oTimeout     (oTimeout),
      .oValid       (oValid),
      .iReady       (iReady),
      .oBusy        (oBusy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      totalCnt++;
      assert (obs === exp) passCnt++;
      else begin
         failCnt++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int sat(input int v);
      return (v > MAXC) ? MAXC : v;
   endfunction

   // Arm from IDLE and measure how long the fine clear is held
   task automatic armClear();
      int n;
      n = 0;
      iArm = 1'b1;
      tick();
      iArm = 1'b0;
      check("busy_armed", 32'(oBusy), 32'd1);
      for (int i = 0; i < 8; i++) begin
         if (oFineRst !== 1'b1) break;
         n++;
         tick();
      end
      check("clear_len", 32'(n), 32'(CLR));
      #1;
      check("start_en_armed", 32'(oStartEnable), 32'd1);
   endtask

   // One measurement: start tap after startDly cycles, stop pulses s1/s2 cycles after it
   task automatic measure(input int startDly, input int s1, input int s2, input int hold);
      int qualOff, doneOff, expC;
      bit expT;
      // reference: first stop whose elapsed count reaches GUARD wins unless timeout comes first
      if (sat(s1 - 1) >= int'(GUARD)) qualOff = s1;
      else                            qualOff = s2;
      expC    = sat(qualOff - 1);
      expT    = 1'b0;
      doneOff = qualOff;
      if (TO_EN && (int'(TMO) < qualOff - 1)) begin
         doneOff = int'(TMO) + 1;
         expC    = int'(TMO);
         expT    = 1'b1;
      end

      armClear();
      repeat (startDly) tick();
      iArbStart = 1'b1;
      #1;
      check("start_freeze", 32'(oStartEnable), 32'd0);
      tick();
      iArbStart = 1'b0;
      for (int off = 1; off <= doneOff; off++) begin
         iArbStop = (off == s1) || (off == s2);
         #1;
         if (iArbStop) check("stop_en", 32'(oStopEnable), (off == qualOff) ? 32'd0 : 32'd1);
         if (off == doneOff) check("valid_early", 32'(oValid), 32'd0);
         tick();
      end
      iArbStop = 1'b0;
      check("valid", 32'(oValid), 32'd1);
      check("coarse", 32'(oCoarse), 32'(expC));
      check("timeout", 32'(oTimeout), 32'(expT));
      lastCoarse = expC;
      for (int h = 0; h < hold; h++) begin
         iArm = 1'($urandom_range(0, 1));
         tick();
         check("hold_valid", 32'(oValid), 32'd1);
         check("hold_coarse", 32'(oCoarse), 32'(expC));
      end
      iArm   = 1'b0;
      iReady = 1'b1;
      tick();
      iReady = 1'b0;
      check("valid_drop", 32'(oValid), 32'd0);
      check("idle_busy", 32'(oBusy), 32'd0);
   endtask

   initial begin
      int s1;
      iRst = 1'b1; iArm = 1'b0; iAbort = 1'b0;
      iArbStart = 1'b0; iArbStop = 1'b0; iReady = 1'b0;
      #1;
      check("rst_finerst", 32'(oFineRst), 32'd1);
      check("rst_valid", 32'(oValid), 32'd0);
      check("rst_coarse", 32'(oCoarse), 32'd0);
      check("rst_busy", 32'(oBusy), 32'd0);
      check("rst_start_en", 32'(oStartEnable), 32'd0);
      check("rst_timeout", 32'(oTimeout), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      iRst = 1'b0;
      tick();
      check("post_rst_finerst", 32'(oFineRst), 32'd0);

      // basic measurement k=4, then guard-suppressed first stop, then long hold
      measure(5, 5, 9, 0);
      measure(1, 1, 4, 0);
      measure(0, 3, 8, 5);

      // late stop: saturates without timeout, times out with it
      measure(0, 1, 30, 1);
      // stop on exactly the timeout count (stop wins when timeout enabled)
      measure(0, 1, int'(TMO) + 1, 0);

      // randomized measurements
      for (int n = 0; n < 16; n++) begin
         s1 = int'($urandom_range(1, 10));
         measure(int'($urandom_range(0, 4)), s1, s1 + int'($urandom_range(1, 20)),
                 int'($urandom_range(0, 3)));
      end

      // abort in WAIT_STOP with a simultaneous qualifying stop
      armClear();
      iArbStart = 1'b1;
      tick();
      iArbStart = 1'b0;
      tick();
      tick();
      iAbort   = 1'b1;
      iArbStop = 1'b1;
      tick();
      iAbort   = 1'b0;
      iArbStop = 1'b0;
      check("abort_busy", 32'(oBusy), 32'd0);
      check("abort_valid", 32'(oValid), 32'd0);
      check("abort_coarse", 32'(oCoarse), 32'(lastCoarse));
      #1;
      check("abort_stop_en", 32'(oStopEnable), 32'd0);

      // arm and abort together in IDLE: no CLEAR
      iArm   = 1'b1;
      iAbort = 1'b1;
      tick();
      iArm   = 1'b0;
      iAbort = 1'b0;
      check("armabort_busy", 32'(oBusy), 32'd0);
      check("armabort_finerst", 32'(oFineRst), 32'd0);

      // asynchronous reset mid-cycle in WAIT_START
      armClear();
      #3;
      iRst = 1'b1;
      #1;
      check("arst_start_en", 32'(oStartEnable), 32'd0);
      check("arst_finerst", 32'(oFineRst), 32'd1);
      check("arst_busy", 32'(oBusy), 32'd0);
      @(negedge clk);
      iRst = 1'b0;
      tick();
      check("arst_idle_busy", 32'(oBusy), 32'd0);
      check("arst_coarse", 32'(oCoarse), 32'd0);
      check("arst_valid", 32'(oValid), 32'd0);
      measure(2, 3, 6, 0);

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
